// File: rtl/cpu_mmio_pkg.sv
// Shared definitions for the CPU-mapped FIFO: register offsets, STATUS/CTRL bit
// positions, FSM state encoding and the captured-request record.
package cpu_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESP       = 2'd1,
    ST_WAIT_SPACE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OFF_DATA   = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_CTRL   = 2'd2,
    OFF_RSVD   = 2'd3
  } reg_off_t;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;
  localparam int CTRL_FLUSH_BIT = 0;

  typedef struct packed {
    reg_off_t    off;
    logic        is_write;
    logic [31:0] wdata;     // already strobe-masked
  } req_t;

  function automatic logic [31:0] apply_strobes(input logic [31:0] data,
                                                input logic [3:0]  strb);
    logic [31:0] masked;
    for (int b = 0; b < 4; b++) begin
      masked[8*b +: 8] = strb[b] ? data[8*b +: 8] : 8'h00;
    end
    return masked;
  endfunction

  function automatic logic [31:0] status_word(input logic       empty,
                                              input logic       full,
                                              input logic [7:0] count);
    logic [31:0] word;
    word                                 = '0;
    word[STAT_EMPTY_BIT]                 = empty;
    word[STAT_FULL_BIT]                  = full;
    word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return word;
  endfunction

endpackage

// File: rtl/cpu_mmio_fifo_if.sv
// Control/status bundle between the MMIO front end and its FIFO store.
interface cpu_mmio_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          flush;
  logic [31:0]   wdata;
  logic [31:0]   head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  modport master (output push, pop, flush, wdata,
                  input  head, full, empty, count);
  modport slave  (input  push, pop, flush, wdata,
                  output head, full, empty, count);
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO: storage, wrap-around pointers and occupancy count.
// Flush wins over everything; pushes when full and pops when empty are dropped.
module sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            resetn,
  cpu_mmio_fifo_if.slave  f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign f.full  = (r_count == CW'(DEPTH));
  assign f.empty = (r_count == '0);
  assign f.count = r_count;
  assign f.head  = r_mem[r_rd_ptr];

  assign w_do_push = f.push && !f.full  && !f.flush;
  assign w_do_pop  = f.pop  && !f.empty && !f.flush;

  // NOTE: storage has no reset; only pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= f.wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (f.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mmio_fifo.sv
// CPU memory-mapped front end for a host-facing FIFO: decodes a 16-byte window,
// runs the request FSM and stalls DATA writes while the FIFO is full.
module cpu_mmio_fifo
  import cpu_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready
);

  state_t      r_state;
  req_t        r_req;
  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;

  reg_off_t    w_off;
  logic        w_is_write;
  logic        w_is_data_write;
  logic [31:0] w_masked;
  logic [31:0] w_read_val;
  logic        w_push;
  logic        w_flush;
  logic [31:0] w_push_data;
  logic        w_unused;

  cpu_mmio_fifo_if #(.DEPTH(DEPTH)) w_fifo ();

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .f      (w_fifo)
  );

  assign sel             = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off           = reg_off_t'(mem_addr[3:2]);
  assign w_is_write      = (|mem_wstrb) && !mem_instr;
  assign w_is_data_write = w_is_write && (w_off == OFF_DATA);
  assign w_masked        = apply_strobes(mem_wdata, mem_wstrb);
  assign w_unused        = ^mem_addr[1:0];

  // STATUS reflects the count as it stands before this access takes effect.
  assign w_read_val = (!w_is_write && !mem_instr && w_off == OFF_STATUS)
                    ? status_word(w_fifo.empty, w_fifo.full, 8'(w_fifo.count))
                    : '0;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_push_data = r_req.wdata;
    case (r_state)
      ST_IDLE: begin
        if (sel && w_is_data_write && !w_fifo.full) begin
          w_push      = 1'b1;
          w_push_data = w_masked;
        end
      end
      ST_WAIT_SPACE: w_push = !w_fifo.full;
      ST_RESP: begin
        w_flush = r_req.is_write && (r_req.off == OFF_CTRL)
                  && r_req.wdata[CTRL_FLUSH_BIT];
      end
      default: ;
    endcase
  end

  assign w_fifo.push  = w_push;
  assign w_fifo.pop   = !w_fifo.empty && i_ready;
  assign w_fifo.flush = w_flush;
  assign w_fifo.wdata = w_push_data;

  assign o_data    = w_fifo.head;
  assign o_valid   = !w_fifo.empty;
  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (sel) begin
            r_req <= '{off: w_off, is_write: w_is_write, wdata: w_masked};
            if (w_is_data_write && w_fifo.full) begin
              r_state <= ST_WAIT_SPACE;
            end else begin
              r_state     <= ST_RESP;
              r_mem_ready <= 1'b1;
              r_mem_rdata <= w_read_val;
            end
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        ST_WAIT_SPACE: begin
          // A slot freed by a pop becomes usable one cycle later.
          if (!w_fifo.full) begin
            r_state     <= ST_RESP;
            r_mem_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mmio_fifo.sv
// Self-checking bench: a queue-based model of the FIFO and bus completion is
// compared every cycle, with literal expectations pinning key results.
module tb_cpu_mmio_fifo;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        i_ready = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sel;
  logic [31:0] o_data;
  logic        o_valid;

  int total = 0;
  int bad   = 0;

  cpu_mmio_fifo #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [31:0] model_q[$];
  bit          m_txn_new, m_in_window, m_is_data_wr, m_is_ctrl_wr, m_is_status_rd;
  bit          m_need_push, m_flush_next, m_ready_exp, chk_en;
  logic [31:0] m_data, m_rdata_exp;

  function automatic logic [31:0] model_status(input int n);
    return 32'(n * 256 + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
  endfunction

  function automatic logic [31:0] model_mask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (s[b]) r = r | (d & (32'hFF << (8 * b)));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    m_txn_new = 0; m_in_window = 0; m_is_data_wr = 0; m_is_ctrl_wr = 0;
    m_is_status_rd = 0; m_need_push = 0; m_flush_next = 0; m_ready_exp = 0;
    m_rdata_exp = '0;
  endtask

  // One clock edge: decide model effects from current inputs, then apply them.
  task automatic tick();
    bit cap, fl, pop, push;
    logic [31:0] rd_next;
    cap  = m_txn_new && mem_valid && m_in_window;
    fl   = m_flush_next;
    pop  = i_ready && (model_q.size() != 0) && !fl;
    push = (m_need_push || (cap && m_is_data_wr)) && (model_q.size() < DEPTH);
    rd_next = m_is_status_rd ? model_status(model_q.size()) : 32'h0;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(m_data);
    end
    m_flush_next = cap && m_is_ctrl_wr && m_data[0];
    m_ready_exp  = push || (cap && !m_is_data_wr);
    m_rdata_exp  = (cap && !m_is_data_wr) ? rd_next : 32'h0;
    if (cap) begin
      m_txn_new = 0;
      if (m_is_data_wr && !push) m_need_push = 1;
    end
    if (push) m_need_push = 0;
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_sel", 32'(sel), 32'(mem_valid && mem_addr >= BASE && mem_addr < BASE + 32'd16));
      check("cmp_o_valid", 32'(o_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) check("cmp_o_data", o_data, model_q[0]);
      check("cmp_mem_ready", 32'(mem_ready), 32'(m_ready_exp));
      check("cmp_mem_rdata", mem_rdata, m_ready_exp ? m_rdata_exp : 32'h0);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic start_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic instr);
    logic [31:0] off;
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb; mem_instr = instr;
    mem_valid = 1'b1;
    m_in_window    = (addr >= BASE) && (addr < BASE + 32'd16);
    off            = (addr - BASE) >> 2;
    m_is_data_wr   = m_in_window && strb != 0 && !instr && off == 0;
    m_is_ctrl_wr   = m_in_window && strb != 0 && !instr && off == 2;
    m_is_status_rd = m_in_window && strb == 0 && !instr && off == 1;
    m_data         = model_mask(wdata, strb);
    m_txn_new      = m_in_window;
  endtask

  task automatic end_access();
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    m_txn_new = 0; m_in_window = 0; m_is_data_wr = 0; m_is_ctrl_wr = 0; m_is_status_rd = 0;
  endtask

  task automatic finish_access(output int lat, output logic [31:0] rdv);
    lat = 0;
    while (!m_ready_exp && lat < 40) begin
      tick();
      lat++;
    end
    if (!m_ready_exp) begin
      total++; bad++;
      $display("FAIL access_timeout: no completion after %0d cycles", lat);
    end
    rdv = mem_rdata;
    check("access_ready", 32'(mem_ready), 32'd1);
    tick();
    end_access();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int l; logic [31:0] r;
    start_access(addr, data, strb, 1'b0);
    finish_access(l, r);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    int l;
    start_access(addr, 32'h0, 4'h0, 1'b0);
    finish_access(l, data);
  endtask

  task automatic pop_one();
    i_ready = 1'b1; tick(); i_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] d;

  initial begin
    model_clear();
    #1 resetn = 1'b0;
    #1;
    check("reset_mem_ready", 32'(mem_ready), 32'd0);
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_mem_rdata", mem_rdata, 32'd0);
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Single write, latency 1, then STATUS
    start_access(BASE, 32'hDEAD_BEEF, 4'hF, 1'b0);
    finish_access(lat, d);
    check("wr_latency", lat, 32'd1);
    check("wr_o_valid", 32'(o_valid), 32'd1);
    check("wr_o_data", o_data, 32'hDEAD_BEEF);
    rd(BASE + 4, d);
    check("status_one", d, 32'h0000_0100);
    pop_one();

    // Partial strobes zero the unstrobed bytes
    wr(BASE, 32'h1234_5678, 4'b0011);
    check("strobe_o_data", o_data, 32'h0000_5678);
    pop_one();

    // Fill, stall the 17th write, release with one pop
    for (int i = 0; i < DEPTH; i++) wr(BASE, 32'hA000_0000 + 32'(i), 4'hF);
    rd(BASE + 4, d);
    check("status_full", d, 32'h0000_1002);
    start_access(BASE, 32'hA000_0010, 4'hF, 1'b0);
    repeat (4) begin
      tick();
      check("stall_no_ready", 32'(mem_ready), 32'd0);
    end
    pop_one();
    check("stall_pop_cycle", 32'(mem_ready), 32'd0);
    finish_access(lat, d);
    check("stall_release_lat", lat, 32'd1);
    check("stall_head", o_data, 32'hA000_0001);
    rd(BASE + 4, d);
    check("status_full_again", d, 32'h0000_1002);

    // Full with a pop in the capture cycle: push deferred one cycle
    start_access(BASE, 32'hA000_0011, 4'hF, 1'b0);
    pop_one();
    check("fullpop_no_ready", 32'(mem_ready), 32'd0);
    finish_access(lat, d);
    check("fullpop_lat", lat, 32'd1);
    check("fullpop_head", o_data, 32'hA000_0002);

    // Drain
    i_ready = 1'b1;
    for (int k = 0; k < 40 && model_q.size() != 0; k++) tick();
    i_ready = 1'b0;
    check("drained", 32'(o_valid), 32'd0);

    // Flush with 5 words queued and the host popping
    for (int i = 0; i < 5; i++) wr(BASE, 32'hB000_0000 + 32'(i), 4'hF);
    rd(BASE + 4, d);
    check("status_five", d, 32'h0000_0500);
    i_ready = 1'b1;
    wr(BASE + 8, 32'h1, 4'hF);
    i_ready = 1'b0;
    check("flush_o_valid", 32'(o_valid), 32'd0);
    rd(BASE + 4, d);
    check("status_after_flush", d, 32'h0000_0001);

    // Non-STATUS reads return 0; STATUS/reserved writes have no effect
    rd(BASE + 0, d);  check("rd_data_reg", d, 32'h0);
    rd(BASE + 8, d);  check("rd_ctrl_reg", d, 32'h0);
    rd(BASE + 12, d); check("rd_rsvd_reg", d, 32'h0);
    wr(BASE + 4, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 12, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 4, d);  check("status_no_side_effect", d, 32'h0000_0001);

    // Out-of-window access and instruction fetch
    wr(BASE, 32'h0000_0055, 4'hF);
    start_access(BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    #1 check("oow_sel", 32'(sel), 32'd0);
    repeat (3) begin
      tick();
      check("oow_no_ready", 32'(mem_ready), 32'd0);
    end
    end_access();
    start_access(BASE + 4, 32'h0, 4'h0, 1'b1);
    finish_access(lat, d);
    check("ifetch_rdata", d, 32'h0);
    rd(BASE + 4, d);
    check("status_after_ifetch", d, 32'h0000_0100);
    pop_one();

    // Simultaneous push and pop leaves count unchanged
    wr(BASE, 32'hC000_0000, 4'hF);
    wr(BASE, 32'hC000_0001, 4'hF);
    start_access(BASE, 32'hC000_0002, 4'hF, 1'b0);
    pop_one();
    finish_access(lat, d);
    check("pushpop_lat", lat, 32'd0);
    rd(BASE + 4, d);
    check("pushpop_status", d, 32'h0000_0200);
    check("pushpop_head", o_data, 32'hC000_0001);

    // Reset while a write is stalled
    for (int i = 0; i < DEPTH - 2; i++) wr(BASE, 32'hD000_0000 + 32'(i), 4'hF);
    start_access(BASE, 32'hD000_00FF, 4'hF, 1'b0);
    repeat (2) tick();
    #2 resetn = 1'b0;
    end_access();
    model_clear();
    #1;
    check("rst_stall_ready", 32'(mem_ready), 32'd0);
    check("rst_stall_o_valid", 32'(o_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) tick();
    check("rst_stall_after", 32'(o_valid), 32'd0);
    rd(BASE + 4, d);
    check("rst_stall_status", d, 32'h0000_0001);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
